// File: rtl/fir_coef_loader.sv
// Double-buffered coefficient store for the serial FIR: streams a set into the shadow bank,
// swaps it active at the next sample boundary, and serves the active bank through a registered read port.
module fir_coef_loader #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned TAPS  = 64,
   parameter int unsigned AW    = $clog2(TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_last,
   input  logic             swap_req,
   input  logic [AW-1:0]    rd_index,
   output logic [WIDTH-1:0] rd_coef,
   output logic             active_bank,
   output logic             load_done,
   output logic             load_err
);

   localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_LOAD,
      ST_DRAIN,
      ST_ERR_DONE,
      ST_PEND
   } state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic             s_ready_q, s_ready_d;
   logic [WIDTH-1:0] rd_coef_q, rd_coef_d;
   logic             active_bank_q, active_bank_d;
   logic             load_done_q, load_done_d;
   logic             load_err_q, load_err_d;

   logic [WIDTH-1:0] bank0_q [TAPS];
   logic [WIDTH-1:0] bank1_q [TAPS];

   logic             xfer;
   logic             we_shadow;
   logic             we_both;
   logic             we0;
   logic             we1;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;

   assign xfer = s_valid & s_ready_q;

   // Next-state, write-port and registered-output logic
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      active_bank_d = active_bank_q;
      load_done_d   = 1'b0;
      load_err_d    = 1'b0;
      we_shadow     = 1'b0;
      we_both       = 1'b0;
      waddr         = wr_ptr_q;
      wdata         = s_data;

      case (state_q)
         ST_CLEAR: begin
            we_both  = 1'b1;
            wdata    = '0;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == LAST_IDX) begin
               state_d  = ST_IDLE;
               wr_ptr_d = '0;
            end
         end
         ST_IDLE: begin
            if (xfer) begin
               we_shadow = 1'b1;
               waddr     = '0;
               wr_ptr_d  = AW'(1);
               state_d   = s_last ? ST_ERR_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               we_shadow = 1'b1;
               wr_ptr_d  = wr_ptr_q + AW'(1);
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d = '0;
                  if (s_last) begin
                     state_d = ST_PEND;
                  end else begin
                     load_err_d = 1'b1;
                     state_d    = ST_DRAIN;
                  end
               end else if (s_last) begin
                  load_err_d = 1'b1;
                  wr_ptr_d   = '0;
                  state_d    = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (xfer && s_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_ERR_DONE: begin
            load_err_d = 1'b1;
            wr_ptr_d   = '0;
            state_d    = ST_IDLE;
         end
         ST_PEND: begin
            if (swap_req) begin
               active_bank_d = ~active_bank_q;
               load_done_d   = 1'b1;
               wr_ptr_d      = '0;
               state_d       = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_CLEAR;
            wr_ptr_d = '0;
         end
      endcase

      s_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DRAIN);

      // Old bank is read in the swap cycle because active_bank_q has not yet toggled
      if (state_q == ST_CLEAR) begin
         rd_coef_d = '0;
      end else if (active_bank_q) begin
         rd_coef_d = bank1_q[rd_index];
      end else begin
         rd_coef_d = bank0_q[rd_index];
      end
   end

   assign we0 = we_both | (we_shadow & active_bank_q);
   assign we1 = we_both | (we_shadow & ~active_bank_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_CLEAR;
         wr_ptr_q      <= '0;
         s_ready_q     <= 1'b0;
         rd_coef_q     <= '0;
         active_bank_q <= 1'b0;
         load_done_q   <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         s_ready_q     <= s_ready_d;
         rd_coef_q     <= rd_coef_d;
         active_bank_q <= active_bank_d;
         load_done_q   <= load_done_d;
         load_err_q    <= load_err_d;
      end
   end

   // Bank storage; contents are restored to zero by the CLEAR sweep after reset
   always_ff @(posedge clk) begin
      if (we0) begin
         bank0_q[waddr] <= wdata;
      end
      if (we1) begin
         bank1_q[waddr] <= wdata;
      end
   end

   assign s_ready     = s_ready_q;
   assign rd_coef     = rd_coef_q;
   assign active_bank = active_bank_q;
   assign load_done   = load_done_q;
   assign load_err    = load_err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: directed scenarios plus randomized sets
// compared against an array model of the active and shadow coefficient sets.
module tb_fir_coef_loader;

   localparam int unsigned WIDTH = 18;
   localparam int unsigned TAPS  = 64;
   localparam int unsigned AW    = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             swap_req;
   logic [AW-1:0]    rd_index;
   logic [WIDTH-1:0] rd_coef;
   logic             active_bank;
   logic             load_done;
   logic             load_err;

   fir_coef_loader #(.WIDTH(WIDTH), .TAPS(TAPS), .AW(AW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .swap_req(swap_req), .rd_index(rd_index), .rd_coef(rd_coef),
      .active_bank(active_bank), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int err_pulses;
   int done_pulses;

   logic [WIDTH-1:0] mdl_active [TAPS];
   logic [WIDTH-1:0] mdl_shadow [TAPS];
   logic             mdl_bank;

   task automatic tick();
      @(posedge clk);
      #1;
      if (load_err === 1'b1) err_pulses++;
      if (load_done === 1'b1) done_pulses++;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
      int budget = 200;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (s_ready !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      if (s_ready !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
      end
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_set(input int len, input bit ramp, input int max_gap);
      logic [WIDTH-1:0] d;
      for (int n = 0; n < len; n++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
         d = ramp ? WIDTH'(n - 32) : WIDTH'($urandom);
         if (n < TAPS) mdl_shadow[n] = d;
         send_word(d, (n == len - 1));
      end
   endtask

   task automatic do_read(input int idx, output logic [WIDTH-1:0] val);
      rd_index = AW'(idx);
      tick();
      val = rd_coef;
   endtask

   task automatic do_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   task automatic model_swap();
      for (int i = 0; i < TAPS; i++) mdl_active[i] = mdl_shadow[i];
      mdl_bank = ~mdl_bank;
   endtask

   task automatic test_reset(input int cyc);
      int  n;
      bit  zero_ok;
      logic [WIDTH-1:0] v;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; swap_req = 1'b0; rd_index = '0; s_data = '0;
      repeat (cyc) @(posedge clk);
      #1 rst = 1'b0;
      n = 0;
      zero_ok = 1'b1;
      while (s_ready !== 1'b1 && n < 200) begin
         if (rd_coef !== '0) zero_ok = 1'b0;
         rd_index = AW'($urandom);
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < TAPS; i++) mdl_active[i] = '0;
      mdl_bank = 1'b0;
      n_cmp++;
      if (n != 64) begin n_bad++; $display("FAIL reset_ready_delay: got %0d cycles required 64", n); end
      n_cmp++;
      if (!zero_ok) begin n_bad++; $display("FAIL reset_clear_reads: rd_coef nonzero during clear required 0"); end
      n_cmp++;
      if (active_bank !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: bank=%b done=%b err=%b required 0 0 0", active_bank, load_done, load_err);
      end
      for (int i = 0; i < TAPS; i++) begin
         do_read(i, v);
         n_cmp++;
         if (v !== '0) begin n_bad++; $display("FAIL reset_read[%0d]: got %h required 0", i, v); end
      end
   endtask

   task automatic test_good_load();
      logic [WIDTH-1:0] v;
      err_pulses = 0; done_pulses = 0;
      send_set(64, 1'b1, 0);
      n_cmp++;
      if (s_ready !== 1'b0) begin n_bad++; $display("FAIL good_ready_drop: s_ready=%b required 0", s_ready); end
      repeat (10) tick();
      n_cmp++;
      if (s_ready !== 1'b0 || done_pulses != 0) begin
         n_bad++; $display("FAIL good_pend_hold: s_ready=%b done=%0d required 0 0", s_ready, done_pulses);
      end
      rd_index = '0;
      do_swap();
      n_cmp++;
      if (load_done !== 1'b1 || active_bank !== 1'b1) begin
         n_bad++; $display("FAIL good_swap: done=%b bank=%b required 1 1", load_done, active_bank);
      end
      n_cmp++;
      if (rd_coef !== mdl_active[0]) begin
         n_bad++; $display("FAIL swap_cycle_read: got %h required %h", rd_coef, mdl_active[0]);
      end
      model_swap();
      tick();
      n_cmp++;
      if (rd_coef !== WIDTH'(-32)) begin n_bad++; $display("FAIL post_swap_read: got %h required %h", rd_coef, WIDTH'(-32)); end
      n_cmp++;
      if (load_done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: load_done=%b required 0", load_done); end
      do_read(5, v);
      n_cmp++;
      if (v !== WIDTH'(-27)) begin n_bad++; $display("FAIL read_idx5: got %h required %h", v, WIDTH'(-27)); end
      do_read(63, v);
      n_cmp++;
      if (v !== WIDTH'(31)) begin n_bad++; $display("FAIL read_idx63: got %h required %h", v, WIDTH'(31)); end
      n_cmp++;
      if (done_pulses != 1 || err_pulses != 0) begin
         n_bad++; $display("FAIL good_pulse_count: done=%0d err=%0d required 1 0", done_pulses, err_pulses);
      end
   endtask

   task automatic test_short_set();
      logic [WIDTH-1:0] v;
      int idx;
      err_pulses = 0; done_pulses = 0;
      send_set(11, 1'b0, 0);
      n_cmp++;
      if (load_err !== 1'b1) begin n_bad++; $display("FAIL short_err: load_err=%b required 1", load_err); end
      repeat (3) tick();
      n_cmp++;
      if (err_pulses != 1 || done_pulses != 0 || active_bank !== mdl_bank) begin
         n_bad++;
         $display("FAIL short_after: err=%0d done=%0d bank=%b required 1 0 %b", err_pulses, done_pulses, active_bank, mdl_bank);
      end
      for (int k = 0; k < 4; k++) begin
         idx = $urandom_range(0, TAPS - 1);
         do_read(idx, v);
         n_cmp++;
         if (v !== mdl_active[idx]) begin n_bad++; $display("FAIL short_read[%0d]: got %h required %h", idx, v, mdl_active[idx]); end
      end
      send_set(64, 1'b0, 2);
      do_swap();
      model_swap();
      n_cmp++;
      if (load_done !== 1'b1 || active_bank !== mdl_bank) begin
         n_bad++; $display("FAIL short_recover_swap: done=%b bank=%b required 1 %b", load_done, active_bank, mdl_bank);
      end
      for (int i = 0; i < TAPS; i++) begin
         do_read(i, v);
         n_cmp++;
         if (v !== mdl_active[i]) begin n_bad++; $display("FAIL recover_read[%0d]: got %h required %h", i, v, mdl_active[i]); end
      end
   endtask

   task automatic test_single_word_last();
      err_pulses = 0;
      send_word(WIDTH'($urandom), 1'b1);
      n_cmp++;
      if (s_ready !== 1'b0 || load_err !== 1'b0) begin
         n_bad++; $display("FAIL errdone_state: s_ready=%b err=%b required 0 0", s_ready, load_err);
      end
      tick();
      n_cmp++;
      if (load_err !== 1'b1 || s_ready !== 1'b1) begin
         n_bad++; $display("FAIL errdone_pulse: err=%b s_ready=%b required 1 1", load_err, s_ready);
      end
      tick();
      n_cmp++;
      if (err_pulses != 1 || active_bank !== mdl_bank) begin
         n_bad++; $display("FAIL errdone_after: err=%0d bank=%b required 1 %b", err_pulses, active_bank, mdl_bank);
      end
   endtask

   task automatic test_long_set();
      logic [WIDTH-1:0] v;
      int idx;
      err_pulses = 0; done_pulses = 0;
      for (int n = 0; n < 70; n++) begin
         send_word(WIDTH'($urandom), (n == 69));
         n_cmp++;
         if (load_err !== (n == 63)) begin
            n_bad++; $display("FAIL long_err_word%0d: load_err=%b required %b", n, load_err, (n == 63));
         end
      end
      n_cmp++;
      if (s_ready !== 1'b1 || err_pulses != 1 || active_bank !== mdl_bank) begin
         n_bad++;
         $display("FAIL long_after: s_ready=%b err=%0d bank=%b required 1 1 %b", s_ready, err_pulses, active_bank, mdl_bank);
      end
      for (int k = 0; k < 4; k++) begin
         idx = $urandom_range(0, TAPS - 1);
         do_read(idx, v);
         n_cmp++;
         if (v !== mdl_active[idx]) begin n_bad++; $display("FAIL long_read[%0d]: got %h required %h", idx, v, mdl_active[idx]); end
      end
      send_set(64, 1'b0, 0);
      s_valid = 1'b1;
      s_data  = WIDTH'($urandom);
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (s_ready !== 1'b0) begin n_bad++; $display("FAIL pend_backpressure[%0d]: s_ready=%b required 0", k, s_ready); end
      end
      s_valid = 1'b0;
      do_swap();
      model_swap();
      n_cmp++;
      if (done_pulses != 1 || active_bank !== mdl_bank) begin
         n_bad++; $display("FAIL long_swap: done=%0d bank=%b required 1 %b", done_pulses, active_bank, mdl_bank);
      end
      for (int i = 0; i < TAPS; i += 7) begin
         do_read(i, v);
         n_cmp++;
         if (v !== mdl_active[i]) begin n_bad++; $display("FAIL bp_read[%0d]: got %h required %h", i, v, mdl_active[i]); end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [WIDTH-1:0] v;
      send_set(30, 1'b0, 0);
      test_reset(1);
      done_pulses = 0;
      do_swap();
      tick();
      n_cmp++;
      if (done_pulses != 0 || active_bank !== 1'b0) begin
         n_bad++; $display("FAIL stray_swap: done=%0d bank=%b required 0 0", done_pulses, active_bank);
      end
      do_read(17, v);
      n_cmp++;
      if (v !== '0) begin n_bad++; $display("FAIL stray_swap_read: got %h required 0", v); end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] v;
      int len, idx, exp_err;
      for (int it = 0; it < 10; it++) begin
         err_pulses = 0; done_pulses = 0;
         if ($urandom_range(0, 1) == 1) do_swap();
         case ($urandom_range(0, 3))
            0, 1:    len = 64;
            2:       len = $urandom_range(1, 63);
            default: len = $urandom_range(65, 70);
         endcase
         exp_err = (len == 64) ? 0 : 1;
         send_set(len, 1'b0, 2);
         if (len == 64) begin
            repeat ($urandom_range(0, 5)) tick();
            n_cmp++;
            if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rnd_pend[%0d]: s_ready=%b required 0", it, s_ready); end
            do_swap();
            model_swap();
         end
         repeat (3) tick();
         n_cmp++;
         if (err_pulses != exp_err || done_pulses != 1 - exp_err || active_bank !== mdl_bank) begin
            n_bad++;
            $display("FAIL rnd_set[%0d] len=%0d: err=%0d done=%0d bank=%b required %0d %0d %b",
                     it, len, err_pulses, done_pulses, active_bank, exp_err, 1 - exp_err, mdl_bank);
         end
         for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, TAPS - 1);
            do_read(idx, v);
            n_cmp++;
            if (v !== mdl_active[idx]) begin
               n_bad++; $display("FAIL rnd_read[%0d][%0d]: got %h required %h", it, idx, v, mdl_active[idx]);
            end
         end
      end
   endtask

   initial begin
      test_reset(2);
      test_good_load();
      test_short_set();
      test_single_word_last();
      test_long_set();
      test_reset_mid_load();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
